// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the data memory responder.
// Contents: RISC-V load/store funct3 encodings, the responder state
// enum, an access-size enum and the lane offsets at which half-word
// accesses are aligned.
package data_memory_responder_pkg;

  // Load encodings. Loads are returned unextended, so the signed and
  // unsigned forms share one data path.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store encodings.
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Byte-lane offsets at which a half-word access is aligned.
  // A word access is aligned only at LANE0.
  localparam logic [1:0] LANE0  = 2'd0;
  localparam logic [1:0] LANE2  = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

endpackage

// File: rtl/data_memory_responder_lane_align.sv
// mem_lane_align: combinational byte-lane steering for one request.
// Ports:
//   func3_i    - load/store funct3
//   off_i      - byte offset within the word (address[1:0])
//   is_read_i  - load request
//   is_write_i - store request
//   wdata_i    - low-lane-justified store data
//   be_o       - byte-enable mask (all zero for an illegal request)
//   wdata_o    - store data shifted onto its lanes
//   rshift_o   - right shift (bits) that low-justifies the read word
//   illegal_o  - misaligned, unsupported funct3 or both read and write
module mem_lane_align
  import data_memory_responder_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  off_i,
  input  logic        is_read_i,
  input  logic        is_write_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [4:0]  rshift_o,
  output logic        illegal_o
);

  size_e size;
  logic  bad_f3;
  logic  misaligned;

  // NOTE: every signal assigned here gets a default at the top of the
  // block so that no path leaves it unassigned and infers a latch.
  always_comb begin
    size       = SZ_WORD;
    bad_f3     = 1'b0;
    misaligned = 1'b0;
    be_o       = 4'b0000;

    if (is_write_i) begin
      case (func3_i)
        F3_SB:   size = SZ_BYTE;
        F3_SH:   size = SZ_HALF;
        F3_SW:   size = SZ_WORD;
        default: bad_f3 = 1'b1;  // includes 100/101, load-only encodings
      endcase
    end else begin
      case (func3_i)
        F3_LB, F3_LBU: size = SZ_BYTE;
        F3_LH, F3_LHU: size = SZ_HALF;
        F3_LW:         size = SZ_WORD;
        default:       bad_f3 = 1'b1;
      endcase
    end

    case (size)
      SZ_BYTE: be_o = 4'b0001 << off_i;
      SZ_HALF: begin
        be_o       = 4'b0011 << off_i;
        misaligned = !(off_i == LANE0 || off_i == LANE2);
      end
      default: begin
        be_o       = 4'b1111;
        misaligned = (off_i != LANE0);
      end
    endcase

    illegal_o = bad_f3 || misaligned || (is_read_i && is_write_i);
    if (illegal_o) be_o = 4'b0000;
  end

  // Lanes outside be_o carry shifted-in junk; the mask discards them.
  assign rshift_o = {off_i, 3'b000};
  assign wdata_o  = wdata_i << rshift_o;

endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: multi-cycle data RAM model for the MEM stage.
// Accepts one load/store per request, stalls with BUSY for LATENCY+1
// cycles (1 cycle for an illegal request), then spends one DONE cycle
// presenting READ_DATA / MEM_ERROR while the pipeline advances.
// Ports:
//   CLK, RESET           - clock (rising edge), async active-low reset
//   MEM_READ, MEM_WRITE  - load / store request
//   FUNC3, ADDRESS       - size/sign and byte address
//   WRITE_DATA           - low-lane-justified store data
//   READ_DATA            - low-lane-justified load data (registered)
//   BUSY                 - pipeline stall request
//   MEM_ERROR            - one-cycle pulse in DONE for an illegal request
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNC3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSY,
  output logic        MEM_ERROR
);

  localparam int WORDS = 1 << (ADDR_WIDTH - 2);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [2:0]              func3_q;
  logic [31:0]             wdata_q;
  logic                    rd_q, wr_q;
  logic [31:0]             read_data_q;
  logic                    mem_error_q;
  logic [31:0]             mem_q [WORDS];

  // Address bits above ADDR_WIDTH are ignored, so the array wraps.
  logic unused_addr_hi;
  assign unused_addr_hi = ^ADDRESS[31:ADDR_WIDTH];

  logic request;
  logic idle;
  assign request = MEM_READ || MEM_WRITE;
  assign idle    = (state_q == IDLE);

  // The aligner judges the live request in IDLE and steers the latched
  // request during ACCESS.
  logic [3:0]  be;
  logic [31:0] wdata_sh;
  logic [4:0]  rshift;
  logic        illegal;

  mem_lane_align u_align (
    .func3_i    (idle ? FUNC3 : func3_q),
    .off_i      (idle ? ADDRESS[1:0] : addr_q[1:0]),
    .is_read_i  (idle ? MEM_READ : rd_q),
    .is_write_i (idle ? MEM_WRITE : wr_q),
    .wdata_i    (idle ? WRITE_DATA : wdata_q),
    .be_o       (be),
    .wdata_o    (wdata_sh),
    .rshift_o   (rshift),
    .illegal_o  (illegal)
  );

  logic [ADDR_WIDTH-3:0] word_idx;
  logic                  commit;
  assign word_idx = addr_q[ADDR_WIDTH-1:2];
  assign commit   = (state_q == ACCESS) && (cnt_q == '0);
  assign cnt_d    = cnt_q - 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      func3_q     <= '0;
      wdata_q     <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      read_data_q <= '0;
      mem_error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (request) begin
            addr_q      <= ADDRESS[ADDR_WIDTH-1:0];
            func3_q     <= FUNC3;
            wdata_q     <= WRITE_DATA;
            rd_q        <= MEM_READ;
            wr_q        <= MEM_WRITE;
            read_data_q <= '0;
            if (illegal) begin
              mem_error_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              cnt_q   <= CNT_LOAD;
              state_q <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            if (!wr_q) read_data_q <= mem_q[word_idx] >> rshift;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          // Any request still asserted here belongs to the finished one.
          mem_error_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset; contents survive RESET. An aborted
  // store never commits because reset forces the FSM out of ACCESS.
  always_ff @(posedge CLK) begin
    if (commit && wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  // BUSY is combinational so the stall starts in the request cycle.
  assign BUSY      = RESET && ((idle && request) || (state_q == ACCESS));
  assign READ_DATA = read_data_q;
  assign MEM_ERROR = mem_error_q;

endmodule
